// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds the FSM state encoding and the tie-break rule used at grant time.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned WDOG_W      = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Data wins a tie unless data also won the previous grant, so fetch never starves.
    function automatic logic pick_data(input logic if_req, input logic dm_req,
                                       input logic last_data);
        return dm_req && (!if_req || !last_data);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, unified memory port and status lines.
// Requesters raise *_req with stable operands and hold it until the matching *_ready pulse.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall;
    logic              err_timeout;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_ready, if_rdata, dm_ready, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, err_timeout
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_ready, if_rdata, dm_ready, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, err_timeout
    );

endinterface

// File: rtl/arb_wdog.sv
// Wait counter for an outstanding memory grant; flags expiry on the LIMIT-th
// consecutive grant cycle without an acknowledge.
module arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of a pipeline.
// One transaction at a time: latch at grant, wait for ack or timeout, pulse ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output arb_state_e   state_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_data_q, last_data_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              granted;
    logic              any_req;
    logic              wd_expired;
    logic              capture;
    logic [DATA_W-1:0] cap_data;

    assign granted = (state_q == GNT_I) || (state_q == GNT_D);
    assign any_req = bus.if_req || bus.dm_req;

    arb_wdog #(.LIMIT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  ((state_q == IDLE) && any_req),
        .en_i     (granted && !bus.mem_ack),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        last_data_d = last_data_q;
        err_d       = err_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        capture     = 1'b0;
        cap_data    = bus.mem_rdata;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (pick_data(bus.if_req, bus.dm_req, last_data_q)) begin
                        state_d     = GNT_D;
                        addr_d      = bus.dm_addr & ALIGN_MASK;
                        we_d        = bus.dm_we;
                        wdata_d     = bus.dm_wdata;
                        last_data_d = 1'b1;
                    end else begin
                        state_d     = GNT_I;
                        addr_d      = bus.if_addr & ALIGN_MASK;
                        we_d        = 1'b0;
                        last_data_d = 1'b0;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (bus.mem_ack) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else if (wd_expired) begin
                    state_d  = RESP;
                    capture  = 1'b1;
                    cap_data = '0;
                    err_d    = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Stores leave the load-data register untouched.
        if (capture) begin
            if (state_q == GNT_I) begin
                if_rdata_d = cap_data;
            end else if (!we_q) begin
                dm_rdata_d = cap_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            last_data_q <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            last_data_q <= last_data_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // last_data_q names the owner of the transaction sitting in RESP.
    assign bus.if_ready    = (state_q == RESP) && !last_data_q && bus.if_req;
    assign bus.dm_ready    = (state_q == RESP) && last_data_q && bus.dm_req;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.mem_req     = granted;
    assign bus.mem_we      = (state_q == GNT_D) && we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.err_timeout = err_q;
    assign bus.stall       = (bus.if_req & ~bus.if_ready) | (bus.dm_req & ~bus.dm_ready);
    assign state_o         = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model:
// grant order, latency, bus contents, returned data, timeout, flush and reset abort.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned TO = 255;

    logic       clk;
    logic       rst;
    arb_state_e state_o;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          exp_who_q[$];
    logic [31:0] ref_mem[64];
    logic [31:0] mem_arr[64];
    logic [31:0] exp_if, exp_dm;
    bit          exp_err;
    bit          model_last_data;
    int          ack_delay;
    bit          mem_mute;
    int          stray_req;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'h200a0005;
        return {8'(i), 8'(~i), 8'h5A, 8'(i * 7)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin : mem_model
        int wait_cnt;
        int stray_done;
        wait_cnt   = 0;
        stray_done = 0;
        for (int i = 0; i < 64; i++) mem_arr[i] = init_word(i);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = $urandom;
                stray_done++;
            end else if (bus.mem_req === 1'b1 && !mem_mute && wait_cnt == ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
                if (bus.mem_we === 1'b1) mem_arr[bus.mem_addr[7:2]] = bus.mem_wdata;
                wait_cnt = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                wait_cnt = (bus.mem_req === 1'b1) ? wait_cnt + 1 : 0;
            end
        end
    end

    // ---------------- driver: one or two simultaneous requests ----------------
    task automatic run_pair(input bit do_if, input logic [31:0] ia,
                            input bit do_dm, input bit we, input logic [31:0] da,
                            input logic [31:0] wd, input int delay, input bit mute);
        bit          own_dm[2];
        logic [31:0] own_addr[2];
        bit          own_we[2];
        logic [31:0] own_wd[2];
        int          lat[2];
        int          start[2];
        int          n;
        int          k;
        bit          data_first;

        n = 0;
        data_first = do_dm && (!do_if || !model_last_data);
        for (int s = 0; s < 2; s++) begin
            bit take_dm;
            take_dm = (s == 0) ? data_first : !data_first;
            if (take_dm && do_dm) begin
                own_dm[n] = 1'b1; own_addr[n] = da; own_we[n] = we; own_wd[n] = wd; n++;
            end else if (!take_dm && do_if) begin
                own_dm[n] = 1'b0; own_addr[n] = ia; own_we[n] = 1'b0; own_wd[n] = '0; n++;
            end
        end

        for (int j = 0; j < n; j++) begin
            start[j] = (j == 0) ? 0 : lat[j-1] + 1;
            lat[j]   = start[j] + (mute ? int'(TO) + 1 : delay + 2);
            if (own_dm[j]) begin
                if (own_we[j]) begin
                    if (!mute) ref_mem[own_addr[j][7:2]] = own_wd[j];
                end else begin
                    exp_dm = mute ? 32'h0 : ref_mem[own_addr[j][7:2]];
                end
                exp_q.push_back(exp_dm);
            end else begin
                exp_if = mute ? 32'h0 : ref_mem[own_addr[j][7:2]];
                exp_q.push_back(exp_if);
            end
            exp_who_q.push_back(own_dm[j]);
        end
        if (mute) exp_err = 1'b1;
        model_last_data = own_dm[n-1];

        ack_delay    = delay;
        mem_mute     = mute;
        bus.if_req   = do_if;
        bus.if_addr  = ia;
        bus.dm_req   = do_dm;
        bus.dm_we    = we;
        bus.dm_addr  = da;
        bus.dm_wdata = wd;
        k = 0;

        for (int cyc = 0; cyc <= lat[n-1]; cyc++) begin
            bit ifp, dmp, if_exp, dm_exp, mreq_exp;
            int o;
            ifp = 0; dmp = 0; if_exp = 0; dm_exp = 0; mreq_exp = 0; o = 0;
            for (int j = 0; j < n; j++) begin
                if (own_dm[j]) begin
                    dmp    = dmp    || (cyc <= lat[j]);
                    dm_exp = dm_exp || (cyc == lat[j]);
                end else begin
                    ifp    = ifp    || (cyc <= lat[j]);
                    if_exp = if_exp || (cyc == lat[j]);
                end
                if (cyc > start[j] && cyc < lat[j]) begin
                    mreq_exp = 1'b1;
                    o = j;
                end
            end

            @(negedge clk);
            check("if_ready", 32'(bus.if_ready), 32'(if_exp));
            check("dm_ready", 32'(bus.dm_ready), 32'(dm_exp));
            check("stall", 32'(bus.stall), 32'((ifp && !if_exp) || (dmp && !dm_exp)));
            check("mem_req", 32'(bus.mem_req), 32'(mreq_exp));
            if (mreq_exp && bus.mem_req === 1'b1) begin
                check("mem_addr", bus.mem_addr, own_addr[o] & 32'hFFFF_FFFC);
                check("mem_we", 32'(bus.mem_we), 32'(own_we[o]));
                if (own_we[o]) check("mem_wdata", bus.mem_wdata, own_wd[o]);
            end
            if (bus.if_ready === 1'b1 || bus.dm_ready === 1'b1) begin
                k++;
                if (exp_q.size() > 0) begin
                    logic [31:0] e;
                    bit          who;
                    e   = exp_q.pop_front();
                    who = exp_who_q.pop_front();
                    check("ready_owner", 32'(bus.dm_ready), 32'(who));
                    check("rdata", (bus.dm_ready === 1'b1) ? bus.dm_rdata : bus.if_rdata, e);
                    check("err_timeout", 32'(bus.err_timeout), 32'(exp_err));
                end
            end

            @(posedge clk);
            #1;
            for (int j = 0; j < n; j++) begin
                if (cyc == lat[j]) begin
                    if (own_dm[j]) bus.dm_req = 1'b0;
                    else           bus.if_req = 1'b0;
                end
            end
            if (!do_dm) begin
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
                bus.dm_we    = 1'($urandom_range(0, 1));
            end
            if (!do_if) bus.if_addr = $urandom;
        end
        check("ready_count", k, n);
        exp_q.delete();
        exp_who_q.delete();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit          saw_resp;
        int          pulses;

        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        ack_delay = 0; mem_mute = 1'b0; stray_req = 0;
        exp_if = '0; exp_dm = '0; exp_err = 1'b0; model_last_data = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_if_ready", 32'(bus.if_ready), 32'h0);
        check("rst_dm_ready", 32'(bus.dm_ready), 32'h0);
        check("rst_err", 32'(bus.err_timeout), 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_dm_rdata", bus.dm_rdata, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fetch only, minimum latency.
        run_pair(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        check("fetch_word2", bus.if_rdata, 32'h200a0005);

        // Simultaneous requests, then back-to-back pairs.
        run_pair(1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        check("pair_dm_word4", bus.dm_rdata, init_word(4));
        run_pair(1'b1, 32'h4, 1'b1, 1'b0, 32'h18, 32'h0, 1, 1'b0);
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h1C, 32'h0, 0, 1'b0);
        run_pair(1'b1, 32'hC, 1'b1, 1'b0, 32'h20, 32'h0, 2, 1'b0);

        // Store then load back.
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h0000000C, 1, 1'b0);
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 0, 1'b0);
        check("store_readback", bus.dm_rdata, 32'h0000000C);

        // Fetch flushed while granted: memory completes, no ready pulse.
        ack_delay = 3; mem_mute = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_gnt", 32'(bus.mem_req), 32'h1);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.if_addr = $urandom;
        saw_resp = 1'b0; pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (state_o == RESP) saw_resp = 1'b1;
            if (bus.if_ready === 1'b1) pulses++;
        end
        check("flush_resp", 32'(saw_resp), 32'h1);
        check("flush_no_ready", pulses, 0);
        check("flush_idle", 32'(state_o), 32'(IDLE));
        model_last_data = 1'b0;
        @(posedge clk); #1;

        // Memory never acks a fetch; flag stays set afterwards.
        run_pair(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1, 1'b0);
        check("timeout_sticky", 32'(bus.err_timeout), 32'h1);

        // Reset during a data grant, then a stray ack while idle.
        ack_delay = 6; mem_mute = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h14;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstgnt_state", 32'(state_o), 32'(GNT_D));
        @(posedge clk); #1;
        rst = 1'b1; bus.dm_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstgnt_idle", 32'(state_o), 32'(IDLE));
        check("rstgnt_mem_req", 32'(bus.mem_req), 32'h0);
        check("rstgnt_err", 32'(bus.err_timeout), 32'h0);
        @(posedge clk); #1;
        stray_req++;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("stray_state", 32'(state_o), 32'(IDLE));
        check("stray_mem_req", 32'(bus.mem_req), 32'h0);
        check("stray_dm_ready", 32'(bus.dm_ready), 32'h0);
        check("stray_dm_rdata", bus.dm_rdata, 32'h0);
        check("stray_if_rdata", bus.if_rdata, 32'h0);
        model_last_data = 1'b0; exp_if = '0; exp_dm = '0; exp_err = 1'b0;
        @(posedge clk); #1;

        // Randomized mix of fetches, loads, stores and simultaneous pairs.
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_pair(kind != 1, 32'($urandom_range(0, 63)) << 2,
                     kind != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                     $urandom, $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, byte-address width; DATA_W, default 32, word width; TIMEOUT, default 255, maximum cycles to wait for mem_ack.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch read request; held until if_ready.
REQ-006 if_addr  in  ADDR_W  fetch byte address (the PC).
REQ-007 if_ready  out  1  one-cycle pulse: if_rdata valid.
REQ-008 if_rdata  out  DATA_W  fetched instruction word.
REQ-009 dm_req  in  1  MEM-stage request (memread|memwrite); held until dm_ready.
REQ-010 dm_we  in  1  1 = write, 0 = read.
REQ-011 dm_addr  in  ADDR_W  data byte address (alures).
REQ-012 dm_wdata  in  DATA_W  store data (rd2).
REQ-013 dm_ready  out  1  one-cycle pulse: access complete, dm_rdata valid for reads.
REQ-014 dm_rdata  out  DATA_W  load data.
REQ-015 mem_req, mem_we  out  1  unified single-port memory request and write enable.
REQ-016 mem_addr  out  ADDR_W  word-aligned address; mem_addr[1:0] SHALL be driven 0.
REQ-017 mem_wdata  out  DATA_W  write data.
REQ-018 mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
REQ-019 mem_ack  in  1  one-cycle completion pulse from memory.
REQ-020 stall  out  1  pipeline hold = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
REQ-021 err_timeout  out  1  sticky timeout flag.

Function
REQ-022 FSM states SHALL be IDLE, GNT_I, GNT_D and RESP.
REQ-023 In IDLE, a pending request SHALL be granted at the clock edge, latching addr, we and wdata into registers.
- The next state is GNT_I or GNT_D.
REQ-024 Arbitration when both are pending: grant data, unless the previous grant was data, in which case grant fetch (no fetch starvation).
REQ-025 In GNT_I and GNT_D, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata SHALL be stable from the latched registers.
- Fetch grants always drive mem_we = 0.
REQ-026 On mem_ack, mem_rdata SHALL be captured, the FSM SHALL go to RESP, and mem_req SHALL drop the same cycle.
REQ-027 In RESP, the owner's ready SHALL pulse for exactly one cycle with rdata valid, then the FSM returns to IDLE.
- Minimum latency: req at cycle 0, mem_req at cycle 1, ack at cycle 1, ready at cycle 2.
REQ-028 if_rdata and dm_rdata SHALL hold their last value until the next capture; writes return dm_rdata unchanged.
REQ-029 If the owner's req is low in RESP (flushed requester), the access SHALL still complete on memory and the ready pulse SHALL be suppressed.
REQ-030 A 9-bit wait counter SHALL clear on grant and increment each GNT cycle without ack.
- On reaching TIMEOUT: err_timeout = 1, captured data = 0, FSM goes to RESP.
REQ-031 mem_ack received in IDLE or RESP SHALL be ignored.
REQ-032 Request changes during a grant SHALL not affect the latched transaction.

Reset
REQ-033 On rst, outputs SHALL be:
- state = IDLE, mem_req = 0, mem_we = 0, if_ready = 0, dm_ready = 0, err_timeout = 0;
- if_rdata, dm_rdata, mem_addr, mem_wdata = 0; last-grant flag = fetch; wait counter = 0.
REQ-034 rst asserted mid-transaction SHALL abort it at the next edge with no ready pulse.
REQ-035 rst SHALL take priority over all other inputs.

Structure
REQ-036 The shared package mem_arb_pkg SHALL hold the state enum, the TIMEOUT default and the ADDR_W/DATA_W defaults.
REQ-037 The wait counter and timeout compare SHALL be the sub-module arb_wdog (clear, enable, expired).

Verification
REQ-038 Fetch only: if_req with if_addr=0x8 and memory word 2 = 0x200a0005, ack after 1 cycle -> if_ready at cycle 2, if_rdata = 0x200a0005, mem_we = 0 throughout.
REQ-039 Simultaneous requests: both if_req and dm_req (read 0x10) raised in IDLE -> data granted first and dm_rdata = mem word 4; fetch granted next; a third back-to-back pair goes fetch after data.
REQ-040 Store: dm_we = 1, dm_addr = 0x8, dm_wdata = 0x0000000C -> mem_we = 1 and mem_addr = 0x8 until ack; dm_ready pulses once; a later read returns 0x0C.
REQ-041 Timeout: memory never acks a fetch -> after TIMEOUT = 255 GNT cycles, err_timeout = 1, if_ready pulses with if_rdata = 0, and the flag stays set until rst.
REQ-042 Flush/reset: if_req drops during GNT_I -> the access completes but no if_ready pulse; separately, rst in GNT_D -> IDLE and mem_req = 0 next cycle, with a late mem_ack ignored.
